// File: rtl/dbus_responder.sv
// dbus_responder: target end of the memory-stage dbus handshake.
// Serves load/store requests from a local 64-bit word SRAM with a fixed,
// programmable response latency. Responses are single-cycle pulses and the
// next request can be accepted in the cycle right after a response.
module dbus_responder #(
  parameter int LATENCY = 3,   // 1..15 cycles from acceptance to resp_data_ok
  parameter int DEPTH   = 256  // words, power of two
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic [31:0] txn_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Only the word index and the low byte (alignment check) matter;
  // higher address bits alias and are never stored.
  localparam int LW = (AW + 3 > 8) ? AW + 3 : 8;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic [LW-1:0]  r_addr;
  logic [2:0]     r_size;
  logic [7:0]     r_strobe;
  logic [63:0]    r_data;
  logic           r_data_ok;
  logic           r_err;
  logic [63:0]    r_resp_data;
  logic [31:0]    r_txn;

  logic [63:0]    r_mem [DEPTH];

  logic [LW-1:0]  w_sel_addr;
  logic [2:0]     w_sel_size;
  logic [AW-1:0]  w_rd_idx;
  logic [AW-1:0]  w_wr_idx;
  logic [63:0]    w_rd_word;
  logic [7:0]     w_align_mask;
  logic           w_misaligned;
  logic           w_go_resp;
  logic           w_wr_en;

  // In IDLE (LATENCY=1 path) the response is formed from the live request
  // fields; in WAIT the latched copies are authoritative.
  assign w_sel_addr   = (r_state == S_IDLE) ? req_addr[LW-1:0] : r_addr;
  assign w_sel_size   = (r_state == S_IDLE) ? req_size : r_size;
  assign w_rd_idx     = w_sel_addr[3 +: AW];
  assign w_wr_idx     = r_addr[3 +: AW];
  assign w_rd_word    = r_mem[w_rd_idx];
  assign w_align_mask = (8'd1 << w_sel_size) - 8'd1;
  assign w_misaligned = |(w_sel_addr[7:0] & w_align_mask);

  // Next cycle is the response cycle. Read data is captured here, which is
  // before the RESP-edge write, so a read+write returns the old word.
  assign w_go_resp = req_valid &&
                     (((r_state == S_IDLE) && (LATENCY == 1)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd0)));

  // Misaligned accesses complete but never modify memory.
  assign w_wr_en = (r_state == S_RESP) && !r_err && (|r_strobe);

  assign resp_addr_ok = r_data_ok;
  assign resp_data_ok = r_data_ok;
  assign resp_data    = r_resp_data;
  assign resp_err     = r_err;
  assign txn_count    = r_txn;

  // Handshake FSM with registered response outputs and transaction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_size      <= 3'd0;
      r_strobe    <= 8'd0;
      r_data      <= 64'd0;
      r_data_ok   <= 1'b0;
      r_err       <= 1'b0;
      r_resp_data <= 64'd0;
      r_txn       <= 32'd0;
    end else begin
      r_data_ok   <= w_go_resp;
      r_err       <= w_go_resp & w_misaligned;
      r_resp_data <= w_go_resp ? w_rd_word : 64'd0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr[LW-1:0];
            r_size   <= req_size;
            r_strobe <= req_strobe;
            r_data   <= req_data;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!req_valid) begin
            // Initiator abandoned the request: no write, no response.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_txn   <= r_txn + 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane write on the response-cycle edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) r_mem[w_wr_idx][8*i +: 8] <= r_data[8*i +: 8];
      end
    end
  end

endmodule
